// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator and capture channels.
package pwm_pkg;

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        STUCK = 2'd3
    } cap_state_t;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 1024;

endpackage

// File: rtl/pwm_capture_sync_edge_det.sv
// Two-flop synchronizer plus history flop; reports the synchronized level and its edges.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rising-to-rising period of a PWM input in clk cycles,
// and flags an input that has stopped toggling.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             stuck,
    output logic             stuck_level,
    output cap_state_t       fsm_state
);

    // meas_valid is a one-cycle strobe with no back-pressure: high_cnt and
    // period_cnt are valid in the cycle it is high and hold until the next strobe.

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic             level, rise, fall;
    logic [CNT_W-1:0] hcnt, pcnt, idle, h_lat;
    logic             quiet_timeout;
    cap_state_t       state, state_next;

    sync_edge_det u_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    // An edge in the same cycle as the timeout wins.
    assign quiet_timeout = (idle >= TIMEOUT_V) && !rise && !fall;
    assign fsm_state     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!en) begin
            state_next = ARM;
        end else begin
            case (state)
                ARM: begin
                    if (rise)               state_next = HIGH;
                    else if (quiet_timeout) state_next = STUCK;
                end
                HIGH: begin
                    if (fall)               state_next = LOW;
                    else if (quiet_timeout) state_next = STUCK;
                end
                LOW: begin
                    if (rise)               state_next = HIGH;
                    else if (quiet_timeout) state_next = STUCK;
                end
                STUCK: begin
                    if (rise)               state_next = HIGH;
                    else if (fall)          state_next = ARM;
                end
                default:                    state_next = ARM;
            endcase
        end
    end

    always_comb begin
        stuck = (state == STUCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt        <= '0;
            pcnt        <= '0;
            idle        <= '0;
            h_lat       <= '0;
            high_cnt    <= '0;
            period_cnt  <= '0;
            meas_valid  <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!en) begin
                hcnt <= '0;
                pcnt <= '0;
                idle <= '0;
            end else begin
                idle <= (rise || fall) ? CNT_ONE : sat_inc(idle);
                case (state)
                    ARM: begin
                        if (rise) begin
                            hcnt <= CNT_ONE;
                            pcnt <= CNT_ONE;
                        end
                    end
                    HIGH: begin
                        hcnt <= sat_inc(hcnt);
                        pcnt <= sat_inc(pcnt);
                        if (fall) begin
                            h_lat <= hcnt;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            period_cnt <= pcnt;
                            high_cnt   <= h_lat;
                            meas_valid <= 1'b1;
                            hcnt       <= CNT_ONE;
                            pcnt       <= CNT_ONE;
                        end else begin
                            pcnt <= sat_inc(pcnt);
                        end
                    end
                    STUCK: begin
                        if (rise) begin
                            hcnt <= CNT_ONE;
                            pcnt <= CNT_ONE;
                        end
                    end
                    default: begin
                        hcnt <= '0;
                        pcnt <= '0;
                    end
                endcase
                if (state != STUCK && state_next == STUCK) begin
                    stuck_level <= level;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed PWM scenarios plus random waveforms against a timestamp model.
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1024;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] high_cnt, period_cnt;
    logic             meas_valid, stuck, stuck_level;
    cap_state_t       fsm_state;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int valid_seen = 0;
    bit checking = 1'b0;
    bit lvl = 1'b0;

    // Model: synchronizer delay line, then timestamps of the edges that bound a period.
    bit sy1, sy2, sy3, m_rise, m_fall;
    bit tracking, fall_seen, m_stuck;
    int t_rise, t_fall, quiet;
    logic [CNT_W-1:0] exp_high = '0, exp_period = '0;
    bit exp_valid, exp_stuck, exp_level;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pwm_in      (pwm_in),
        .high_cnt    (high_cnt),
        .period_cnt  (period_cnt),
        .meas_valid  (meas_valid),
        .stuck       (stuck),
        .stuck_level (stuck_level),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            {sy1, sy2, sy3} = 3'b000;
            tracking  = 1'b0;
            fall_seen = 1'b0;
            m_stuck   = 1'b0;
            quiet     = 0;
            exp_high  = '0;
            exp_period = '0;
            exp_valid = 1'b0;
            exp_level = 1'b0;
        end else begin
            m_rise = sy2 & ~sy3;
            m_fall = ~sy2 & sy3;
            exp_valid = 1'b0;
            if (!en) begin
                tracking = 1'b0;
                m_stuck  = 1'b0;
                quiet    = 0;
            end else if (m_rise) begin
                if (tracking && fall_seen) begin
                    exp_period = CNT_W'(sat(cyc - t_rise));
                    exp_high   = CNT_W'(sat(t_fall - t_rise));
                    exp_valid  = 1'b1;
                end
                tracking  = 1'b1;
                fall_seen = 1'b0;
                t_rise    = cyc;
                m_stuck   = 1'b0;
                quiet     = 1;
            end else if (m_fall) begin
                if (tracking && !fall_seen) begin
                    fall_seen = 1'b1;
                    t_fall    = cyc;
                end
                m_stuck = 1'b0;
                quiet   = 1;
            end else begin
                if (!m_stuck && quiet >= TIMEOUT) begin
                    m_stuck   = 1'b1;
                    exp_level = sy2;
                    tracking  = 1'b0;
                end
                quiet++;
            end
            sy3 = sy2;
            sy2 = sy1;
            sy1 = pwm_in;
        end
        exp_stuck = m_stuck;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 50)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("meas_valid", 32'(meas_valid), 32'(exp_valid));
            chk("high_cnt", 32'(high_cnt), 32'(exp_high));
            chk("period_cnt", 32'(period_cnt), 32'(exp_period));
            chk("stuck", 32'(stuck), 32'(exp_stuck));
            if (exp_stuck) chk("stuck_level", 32'(stuck_level), 32'(exp_level));
            if (meas_valid === 1'b1) valid_seen++;
        end
    end

    task automatic hold(input bit v, input int n);
        pwm_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pwm_periods(input int duty, input int n);
        for (int i = 0; i < n; i++) begin
            if (duty >= 255) begin
                hold(1'b1, 256);
            end else begin
                hold(1'b1, duty + 1);
                hold(1'b0, 255 - duty);
            end
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_high_cnt", 32'(high_cnt), 0);
        chk("reset_period_cnt", 32'(period_cnt), 0);
        chk("reset_meas_valid", 32'(meas_valid), 0);
        chk("reset_stuck", 32'(stuck), 0);
        rst = 1'b0;
        en = 1'b1;
        checking = 1'b1;

        valid_seen = 0;
        pwm_periods(100, 4);
        chk("d100_valid_count", valid_seen, 3);
        chk("d100_high", 32'(high_cnt), 101);
        chk("d100_period", 32'(period_cnt), 256);

        valid_seen = 0;
        pwm_periods(0, 4);
        chk("d0_valid_count", valid_seen, 4);
        chk("d0_high", 32'(high_cnt), 1);
        chk("d0_period", 32'(period_cnt), 256);
        chk("d0_stuck", 32'(stuck), 0);

        valid_seen = 0;
        pwm_periods(255, 5);
        chk("d255_valid_count", valid_seen, 1);
        chk("d255_stuck", 32'(stuck), 1);
        chk("d255_level", 32'(stuck_level), 1);

        pwm_in = 1'b0;
        pulse_rst();
        hold(1'b0, 1100);
        chk("low_stuck", 32'(stuck), 1);
        chk("low_level", 32'(stuck_level), 0);
        valid_seen = 0;
        for (int i = 0; i < 4; i++) begin
            hold(1'b1, 50);
            hold(1'b0, 30);
        end
        chk("w50_stuck", 32'(stuck), 0);
        chk("w50_valid_count", valid_seen, 3);
        chk("w50_high", 32'(high_cnt), 50);
        chk("w50_period", 32'(period_cnt), 80);

        pwm_periods(100, 2);
        hold(1'b1, 50);
        pulse_rst();
        chk("midrst_high", 32'(high_cnt), 0);
        chk("midrst_period", 32'(period_cnt), 0);
        chk("midrst_valid", 32'(meas_valid), 0);
        hold(1'b1, 50);
        hold(1'b0, 155);
        pwm_periods(100, 2);

        pwm_periods(100, 2);
        hold(1'b1, 20);
        en = 1'b0;
        hold(1'b1, 10);
        chk("en_off_high", 32'(high_cnt), 101);
        chk("en_off_period", 32'(period_cnt), 256);
        chk("en_off_stuck", 32'(stuck), 0);
        en = 1'b1;
        hold(1'b1, 71);
        hold(1'b0, 155);
        valid_seen = 0;
        pwm_periods(100, 2);
        chk("en_back_valid_count", valid_seen, 1);
        chk("en_back_high", 32'(high_cnt), 101);
        chk("en_back_period", 32'(period_cnt), 256);

        hold(1'b1, TIMEOUT);
        hold(1'b0, TIMEOUT);
        hold(1'b1, TIMEOUT + 8);
        chk("boundary_stuck", 32'(stuck), 1);
        hold(1'b0, 20);

        lvl = 1'b1;
        for (int i = 0; i < 160; i++) begin
            int len;
            if ($urandom_range(0, 19) == 0) len = $urandom_range(TIMEOUT - 2, TIMEOUT + 3);
            else len = $urandom_range(1, 40);
            if ($urandom_range(0, 24) == 0) begin
                en = 1'b0;
                hold(lvl, $urandom_range(1, 5));
                en = 1'b1;
            end else if ($urandom_range(0, 59) == 0) begin
                pulse_rst();
            end
            hold(lvl, len);
            lvl = ~lvl;
        end
        hold(1'b0, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
